// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for video fetch, Z80 CPU and bulk loader.
// One fixed-length slot per access (LAT+2 cycles); priority video > CPU > loader with a loader starvation guard.
module mem_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vreq,
    input  logic [AW-1:0] va,
    output logic          vack,
    output logic [DW-1:0] vq,
    input  logic          creq,
    input  logic          cwr,
    input  logic [AW-1:0] ca,
    input  logic [DW-1:0] cd,
    output logic          cack,
    output logic [DW-1:0] cq,
    input  logic          lreq,
    input  logic          lwr,
    input  logic [AW-1:0] la,
    input  logic [DW-1:0] ld,
    output logic          lack,
    output logic [DW-1:0] lq,
    output logic [AW-1:0] ramA,
    output logic [DW-1:0] ramD,
    output logic          ramWe,
    input  logic [DW-1:0] ramQ,
    output logic          busy
);

    localparam int NR = 3;
    localparam int CW = 3;
    localparam int SW = 4;

    localparam logic [1:0] ID_VID = 2'd0;
    localparam logic [1:0] ID_CPU = 2'd1;
    localparam logic [1:0] ID_LDR = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    win_q, win_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic          ram_we_q, ram_we_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          q_load;

    logic [1:0]    gnt_id;
    logic          gnt_any;
    logic          sel_wr;
    logic [AW-1:0] sel_a;
    logic [DW-1:0] sel_d;

    logic [NR-1:0] ack_w;
    logic [DW-1:0] q_q [NR];

    // Loader jumps the CPU only once the CPU has taken STARVE slots in a row while it waited.
    always_comb begin
        gnt_any = vreq | creq | lreq;
        if (vreq) begin
            gnt_id = ID_VID;
        end else if (lreq && (starve_q == SW'(STARVE))) begin
            gnt_id = ID_LDR;
        end else if (creq) begin
            gnt_id = ID_CPU;
        end else begin
            gnt_id = ID_LDR;
        end
    end

    always_comb begin
        sel_wr = 1'b0;
        sel_a  = va;
        sel_d  = '0;
        case (gnt_id)
            ID_CPU: begin
                sel_wr = cwr;
                sel_a  = ca;
                sel_d  = cd;
            end
            ID_LDR: begin
                sel_wr = lwr;
                sel_a  = la;
                sel_d  = ld;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        wr_d     = wr_q;
        ram_a_d  = ram_a_q;
        ram_d_d  = ram_d_q;
        ram_we_d = 1'b0;
        starve_d = starve_q;
        q_load   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!lreq) begin
                    starve_d = '0;
                end
                if (gnt_any) begin
                    state_d = S_RUN;
                    cnt_d   = CW'(LAT - 1);
                    win_d   = gnt_id;
                    wr_d    = sel_wr;
                    ram_a_d = sel_a;
                    if (sel_wr) begin
                        ram_d_d  = sel_d;
                        ram_we_d = 1'b1;
                    end
                    if (gnt_id == ID_LDR) begin
                        starve_d = '0;
                    end else if ((gnt_id == ID_CPU) && lreq && (starve_q != SW'(STARVE))) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    q_load  = ~wr_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            win_q    <= ID_VID;
            wr_q     <= 1'b0;
            ram_a_q  <= '0;
            ram_d_q  <= '0;
            ram_we_q <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            wr_q     <= wr_d;
            ram_a_q  <= ram_a_d;
            ram_d_q  <= ram_d_d;
            ram_we_q <= ram_we_d;
            starve_q <= starve_d;
        end
    end

    // Read data is captured on the edge entering ACK so q is already valid while ack is high.
    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_req
            assign ack_w[gi] = (state_q == S_ACK) && (win_q == 2'(gi));

            always_ff @(posedge clock) begin
                if (reset) begin
                    q_q[gi] <= '0;
                end else if (q_load && (win_q == 2'(gi))) begin
                    q_q[gi] <= ramQ;
                end
            end
        end
    endgenerate

    assign vack  = ack_w[0];
    assign cack  = ack_w[1];
    assign lack  = ack_w[2];
    assign vq    = q_q[0];
    assign cq    = q_q[1];
    assign lq    = q_q[2];
    assign ramA  = ram_a_q;
    assign ramD  = ram_d_q;
    assign ramWe = ram_we_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random requester traffic,
// checked every cycle against a slot-timing model with a shadow copy of RAM.
module tb_mem_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 8;
    localparam int LAT    = 2;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vreq, creq, cwr, lreq, lwr;
    logic [AW-1:0] va, ca, la;
    logic [DW-1:0] cd, ld;
    logic          vack, cack, lack, ramWe, busy;
    logic [DW-1:0] vq, cq, lq, ramD, ramQ;
    logic [AW-1:0] ramA;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .STARVE(STARVE)) dut (
        .clock(clk), .reset(reset),
        .vreq(vreq), .va(va), .vack(vack), .vq(vq),
        .creq(creq), .cwr(cwr), .ca(ca), .cd(cd), .cack(cack), .cq(cq),
        .lreq(lreq), .lwr(lwr), .la(la), .ld(ld), .lack(lack), .lq(lq),
        .ramA(ramA), .ramD(ramD), .ramWe(ramWe), .ramQ(ramQ), .busy(busy)
    );

    function automatic logic [7:0] init_val(input int i);
        if (i == 32'h1234) return 8'hA5;
        return 8'(i * 37 + (i >> 8));
    endfunction

    // RAM with one registered read stage; preloaded on the first clock edge.
    logic [7:0] ram_mem [0:65535];
    bit         ram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < 65536; i++) ram_mem[i] <= init_val(i);
            ram_init_done <= 1'b1;
        end else begin
            if (ramWe) ram_mem[ramA] <= ramD;
            ramQ <= ram_mem[ramA];
        end
    end

    // Reference model state
    logic [7:0]  ref_mem [0:65535];
    int          cyc = 0;
    int          next_free = 0;
    int          g = 0;
    bit          slot_valid = 1'b0;
    int          m_win = 0;
    bit          m_wr = 1'b0;
    logic [15:0] m_a = '0;
    logic [7:0]  m_d = '0;
    logic [7:0]  m_rdat = '0;
    int          m_starve = 0;
    logic [15:0] e_ramA = '0;
    logic [7:0]  e_ramD = '0;
    logic [7:0]  e_q [3];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    bit v_hold = 1'b0, c_hold = 1'b0, l_hold = 1'b0;
    int ack_id [$];
    int ack_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    // Advance one clock: fold the previous cycle's inputs into the model, then compare outputs.
    task automatic tick();
        logic [2:0] e_ack;
        logic       e_busy, e_we;
        @(posedge clk);
        if (reset) begin
            slot_valid = 1'b0;
            e_ramA = '0;
            e_ramD = '0;
            for (int i = 0; i < 3; i++) e_q[i] = '0;
            m_starve = 0;
            next_free = cyc + 1;
        end else if (cyc >= next_free) begin
            if (!lreq) m_starve = 0;
            if (vreq || creq || lreq) begin
                if (vreq) m_win = 0;
                else if (lreq && m_starve == STARVE) m_win = 2;
                else if (creq) m_win = 1;
                else m_win = 2;
                case (m_win)
                    0: begin m_wr = 1'b0; m_a = va; end
                    1: begin m_wr = cwr;  m_a = ca; m_d = cd; end
                    default: begin m_wr = lwr; m_a = la; m_d = ld; end
                endcase
                if (m_wr) ref_mem[m_a] = m_d;
                else m_rdat = ref_mem[m_a];
                if (m_win == 2) m_starve = 0;
                else if (m_win == 1 && lreq && m_starve < STARVE) m_starve++;
                g = cyc;
                slot_valid = 1'b1;
                next_free = cyc + LAT + 2;
                e_ramA = m_a;
                if (m_wr) e_ramD = m_d;
            end
        end
        cyc++;
        e_ack = '0;
        if (slot_valid && cyc == g + LAT + 1) begin
            e_ack[m_win] = 1'b1;
            if (!m_wr) e_q[m_win] = m_rdat;
        end
        e_busy = slot_valid && cyc > g && cyc <= g + LAT + 1;
        e_we   = slot_valid && m_wr && cyc == g + 1;
        #1;
        chk("acks", {29'd0, lack, cack, vack}, {29'd0, e_ack});
        chk("ack_onehot", 32'($countones({vack, cack, lack}) <= 1), 32'd1);
        chk("busy", busy, e_busy);
        chk("ramWe", ramWe, e_we);
        chk("ramA", ramA, e_ramA);
        chk("ramD", ramD, e_ramD);
        chk("vq", vq, e_q[0]);
        chk("cq", cq, e_q[1]);
        chk("lq", lq, e_q[2]);
        if (vack || cack || lack) begin
            ack_id.push_back(vack ? 0 : (cack ? 1 : 2));
            ack_cyc.push_back(cyc);
            $display("cyc=%0d ack %s vq=%02h cq=%02h lq=%02h", cyc,
                     vack ? "video" : (cack ? "cpu" : "loader"), vq, cq, lq);
        end
        if (vack && !v_hold) vreq = 1'b0;
        if (cack && !c_hold) creq = 1'b0;
        if (lack && !l_hold) lreq = 1'b0;
    endtask

    function automatic logic [15:0] rnd_addr();
        return 16'h3000 | 16'($urandom_range(15));
    endfunction

    int t0;
    int n_c;

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
        for (int i = 0; i < 3; i++) e_q[i] = '0;
        reset = 1'b1;
        vreq = 0; creq = 0; lreq = 0; cwr = 0; lwr = 0;
        va = '0; ca = '0; la = '0; cd = '0; ld = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Single CPU read of the preloaded location
        t0 = cyc; ack_id.delete(); ack_cyc.delete();
        creq = 1; cwr = 0; ca = 16'h1234;
        repeat (5) tick();
        chk("t1_nack", ack_id.size(), 1);
        chk("t1_id", ack_id[0], 1);
        chk("t1_cyc", ack_cyc[0], t0 + 3);
        chk("t1_cq", cq, 8'hA5);

        // CPU write: strobe in cycle 1, ack in cycle 3, cq untouched
        t0 = cyc; ack_id.delete(); ack_cyc.delete();
        creq = 1; cwr = 1; ca = 16'h4000; cd = 8'h3C;
        tick();
        chk("t2_we", ramWe, 1);
        chk("t2_ramA", ramA, 16'h4000);
        chk("t2_ramD", ramD, 8'h3C);
        repeat (3) tick();
        chk("t2_cyc", ack_cyc[0], t0 + 3);
        chk("t2_cq", cq, 8'hA5);

        // All three requesters at once
        t0 = cyc; ack_id.delete(); ack_cyc.delete();
        vreq = 1; va = 16'h0100;
        creq = 1; cwr = 0; ca = 16'h1234;
        lreq = 1; lwr = 0; la = 16'h4000;
        repeat (12) tick();
        chk("t3_nack", ack_id.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_id", ack_id[i], i);
            chk("t3_cyc", ack_cyc[i], t0 + 3 + 4 * i);
        end
        chk("t3_lq", lq, 8'h3C);
        repeat (2) tick();

        // CPU and loader both held: loader forced in after STARVE CPU grants
        ack_id.delete(); ack_cyc.delete();
        c_hold = 1; l_hold = 1;
        creq = 1; cwr = 1; ca = 16'h2000; cd = 8'h11;
        lreq = 1; lwr = 1; la = 16'h2001; ld = 8'h22;
        repeat (10 * (LAT + 2)) tick();
        chk("t4_nack", 32'(ack_id.size() >= 10), 1);
        for (int i = 0; i < 10; i++)
            chk("t4_seq", ack_id[i], (i % (STARVE + 1) == STARVE) ? 2 : 1);
        c_hold = 0; l_hold = 0; creq = 0; lreq = 0;
        repeat (6) tick();

        // Video held blocks the CPU; releasing it lets the CPU in on the next slot
        ack_id.delete(); ack_cyc.delete();
        v_hold = 1; vreq = 1; va = 16'h0200;
        creq = 1; cwr = 0; ca = 16'h0201;
        repeat (16) tick();
        n_c = 0;
        foreach (ack_id[i]) if (ack_id[i] == 1) n_c++;
        chk("t5_no_cack", n_c, 0);
        for (int i = 0; i < 8 && !vack; i++) tick();
        chk("t5_vack_seen", vack, 1);
        v_hold = 0; vreq = 0;
        t0 = cyc; ack_id.delete(); ack_cyc.delete();
        repeat (6) tick();
        chk("t5_id", ack_id[0], 1);
        chk("t5_cyc", ack_cyc[0], t0 + 4);

        // Reset in cycle 2 of a CPU write slot
        t0 = cyc;
        creq = 1; cwr = 1; ca = 16'h4100; cd = 8'h77;
        repeat (2) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("t6_cack", cack, 0);
        chk("t6_busy", busy, 0);
        chk("t6_we", ramWe, 0);
        chk("t6_vq", vq, 0);
        chk("t6_cq", cq, 0);
        chk("t6_lq", lq, 0);
        ack_id.delete(); ack_cyc.delete();
        repeat (5) tick();
        chk("t6_id", ack_id[0], 1);
        chk("t6_cyc", ack_cyc[0], t0 + 6);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(249) == 0);
            if (!vreq && $urandom_range(3) == 0) begin
                vreq = 1; va = rnd_addr();
            end
            if (!creq && $urandom_range(2) == 0) begin
                creq = 1; cwr = 1'($urandom_range(1)); ca = rnd_addr(); cd = 8'($urandom);
            end
            if (!lreq && $urandom_range(2) == 0) begin
                lreq = 1; lwr = 1'($urandom_range(1)); la = rnd_addr(); ld = 8'($urandom);
            end
            tick();
        end
        reset = 0; vreq = 0; creq = 0; lreq = 0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port system RAM between three requesters: video fetch, Z80 CPU and a bulk loader (ROM/cassette image DMA).
- Sits between the CPU/CRTC glue and the RAM primitive (BRAM, SRAM or SDRAM front end), which the memory path currently drives directly.
- Serialises accesses through a fixed-length slot.
- Priority is video > CPU > loader, with a starvation guard for the loader.

Parameters:
AW, 16, address width of requesters and RAM
DW, 8, data width
LAT, 2, RAM read latency in clock cycles (1..7); also the slot length minus one
STARVE, 4, consecutive CPU grants tolerated while loader pending before loader is forced in (1..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
vreq  in  1  video read request, level, held until vack
va  in  AW  video address
vack  out  1  one-cycle pulse, vq valid
vq  out  DW  video read data, held until next video ack
creq  in  1  CPU request, level
cwr  in  1  CPU write (1) / read (0)
ca  in  AW  CPU address
cd  in  DW  CPU write data
cack  out  1  one-cycle pulse, access complete
cq  out  DW  CPU read data, held until next CPU read ack
lreq  in  1  loader request, level
lwr  in  1  loader write/read
la  in  AW  loader address
ld  in  DW  loader write data
lack  out  1  one-cycle pulse
lq  out  DW  loader read data, held
ramA  out  AW  RAM address
ramD  out  DW  RAM write data
ramWe  out  1  RAM write strobe
ramQ  in  DW  RAM read data
busy  out  1  high while a slot is in progress

Behaviour:
- Reset: state IDLE. vack, cack, lack, ramWe and busy = 0. ramA, ramD, vq, cq, lq = 0. Starvation counter = 0.
- Reset asserted mid-slot aborts the slot: no ack issued and no further ramWe.
- FSM states: IDLE, RUN, ACK.
- IDLE: if any request is high, grant in the same cycle (cycle G).
  - Latch the winner id; drive ramA (and ramD/ramWe for a write) from its inputs on the registered edge.
  - Go to RUN with a count of LAT-1.
  - No request: stay in IDLE.
- ramWe is high for exactly one cycle (G+1) on a write grant, 0 otherwise. ramA/ramD hold for the whole slot.
- RUN: count down. At zero go to ACK.
- ACK (cycle G+LAT+1):
  - Pulse the winner's ack.
  - On a read, register ramQ into that requester's q in the same edge that raises ack, so q is valid while ack is high.
  - Next state is IDLE. A new grant may occur in the IDLE cycle right after ACK.
  - Slot length is LAT+2 cycles, grant to next grant.
- busy = 1 from G+1 through the ACK cycle.
- Arbitration in IDLE:
  - vreq wins unconditionally.
  - Otherwise, if lreq and the starvation counter = STARVE, the loader wins.
  - Otherwise creq wins. Otherwise lreq wins.
- Starvation counter:
  - Increments (saturating at STARVE) on each CPU grant while lreq is high.
  - Clears on a loader grant or whenever lreq is low in IDLE.
  - Video grants leave it unchanged.
- A requester that keeps req high after its ack is eligible in the next IDLE cycle; each ack completes one access.
- Requesters must hold address, data and wr stable from req rise until ack. The arbiter samples them only at grant.
- Dropping req before ack does not cancel a granted slot: the ack is still pulsed.
- Simultaneous requests are resolved only by the priority rule; no two acks are ever high together.
- Write acks leave the q registers unchanged.

Test Plan:
- Single CPU read, LAT=2, RAM[0x1234]=0xA5: creq=1, cwr=0, ca=0x1234 at cycle 0 -> ramA=0x1234 from cycle 1, cack pulse at cycle 3 with cq=0xA5, ramWe never high.
- CPU write ca=0x4000, cd=0x3C -> ramWe high exactly cycle 1 with ramA=0x4000, ramD=0x3C; cack at cycle 3; cq unchanged.
- vreq, creq and lreq all raised at cycle 0 -> grant order video (vack cycle 3), CPU (cack cycle 7), loader (lack cycle 11); never two acks in the same cycle.
- creq and lreq held high continuously with STARVE=4 -> ack sequence C,C,C,C,L,C,C,C,C,L,…; with STARVE=1 it alternates C,L.
- vreq held high plus creq -> video gets every slot and cack never fires; drop vreq -> cack in the following slot.
- Assert reset for 1 cycle at cycle 2 of a CPU write slot -> no cack, ramWe=0, busy=0, all q=0; a new creq after reset is granted in the first cycle reset is low.
